// File: rtl/fetch_pkg.sv
// +----------------------------------------------------------------------+
// | fetch_pkg: shared types and constants for the fetch stage            |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int          c_pc_step  = 2;
  localparam logic [7:0]  c_reset_pc = 8'h00;
  localparam logic [7:0]  c_nop      = 8'h00;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/fetch_pc_reg.sv
// +----------------------------------------------------------------------+
// | fetch_pc_reg: program counter with increment, redirect and hold      |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                PC_STEP  = c_pc_step,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_reset_pc)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_incr,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_target,
  output logic [ADDR_W-1:0] o_pc
);

  localparam logic [ADDR_W-1:0] c_step     = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] c_even_msk = ~ADDR_W'(1);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_target_even;

  // Instructions live on even addresses, so redirects are aligned down.
  assign w_target_even = i_target & c_even_msk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (i_redirect) begin
      r_pc <= w_target_even;
    end else if (i_incr) begin
      r_pc <= r_pc + c_step;
    end
  end

  assign o_pc = r_pc;

endmodule : fetch_pc_reg

`default_nettype wire

// File: rtl/fetch_unit.sv
// +----------------------------------------------------------------------+
// | fetch_unit: PC + instruction register stage with decode handshake    |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter int                PC_STEP  = c_pc_step,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_reset_pc),
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc_address,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              running,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_instr_valid;
  logic [CNT_W-1:0]  r_fetch_count;
  logic [ADDR_W-1:0] w_pc;
  logic              w_run;
  logic              w_redirect;
  logic              w_load;
  logic              w_accept;

  assign w_run      = (r_state == RUN);
  assign w_redirect = w_run && branch_en;
  // A redirect squashes this cycle's fetch regardless of backpressure.
  assign w_load     = w_run && !branch_en && (!r_instr_valid || instr_ready);
  assign w_accept   = r_instr_valid && instr_ready;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .PC_STEP  (PC_STEP),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .i_incr     (w_load),
    .i_redirect (w_redirect),
    .i_target   (branch_target),
    .o_pc       (w_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (halt)  w_state_next = HALTED;
      HALTED:  if (start) w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr       <= DATA_W'(c_nop);
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else if (w_redirect) begin
      r_instr_valid <= 1'b0;
    end else if (w_load) begin
      r_instr       <= imem_data;
      r_instr_pc    <= w_pc;
      r_instr_valid <= 1'b1;
    end else if (w_accept) begin
      r_instr_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_count <= '0;
    end else if (w_accept && (r_fetch_count != c_cnt_max)) begin
      r_fetch_count <= r_fetch_count + CNT_W'(1);
    end
  end

  assign pc_address  = w_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign running     = w_run;
  assign fetch_count = r_fetch_count;

endmodule : fetch_unit

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// +----------------------------------------------------------------------+
// | tb_fetch_unit: directed self-checking bench for fetch_unit           |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, halt, branch_en, instr_ready;
  logic [7:0] branch_target;

  logic [7:0]  a_pc, a_imem, a_instr, a_instr_pc;
  logic        a_valid, a_running;
  logic [15:0] a_count;

  logic [7:0]  b_pc, b_imem, b_instr, b_instr_pc;
  logic        b_valid, b_running;
  logic [3:0]  b_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [7:0] addr);
    case (addr)
      8'h02:   return 8'hD3;
      8'h04:   return 8'h50;
      8'h06:   return 8'hD1;
      8'h08:   return 8'h51;
      8'h0A:   return 8'h10;
      default: return 8'h00;
    endcase
  endfunction

  assign a_imem = mem(a_pc);
  assign b_imem = mem(b_pc);

  fetch_unit u_dut_a (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .pc_address(a_pc), .imem_data(a_imem),
    .branch_en(branch_en), .branch_target(branch_target),
    .instr(a_instr), .instr_pc(a_instr_pc), .instr_valid(a_valid),
    .instr_ready(instr_ready), .running(a_running), .fetch_count(a_count)
  );

  fetch_unit #(.RESET_PC(8'hFC), .CNT_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .pc_address(b_pc), .imem_data(b_imem),
    .branch_en(branch_en), .branch_target(branch_target),
    .instr(b_instr), .instr_pc(b_instr_pc), .instr_valid(b_valid),
    .instr_ready(instr_ready), .running(b_running), .fetch_count(b_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ir(input string tag, input logic [7:0] ins, input logic [7:0] ipc,
                          input logic [7:0] pc, input logic vld);
    check({tag, ".instr"}, 32'(a_instr), 32'(ins));
    check({tag, ".instr_pc"}, 32'(a_instr_pc), 32'(ipc));
    check({tag, ".pc"}, 32'(a_pc), 32'(pc));
    check({tag, ".valid"}, 32'(a_valid), 32'(vld));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt = 1'b0; branch_en = 1'b0;
    branch_target = 8'h00; instr_ready = 1'b0;
    step();
    check_ir("rst", 8'h00, 8'h00, 8'h00, 1'b0);
    check("rst.count", 32'(a_count), 32'h0);
    check("rst.running", 32'(a_running), 32'h0);
    check("rst.pc_b", 32'(b_pc), 32'hFC);

    // Start streaming with decode always ready
    reset = 1'b0; start = 1'b1; instr_ready = 1'b1;
    step();
    start = 1'b0;
    check("start.running", 32'(a_running), 32'h1);
    check("start.pc", 32'(a_pc), 32'h00);
    check("wrap0", 32'(b_pc), 32'hFC);
    step();
    check_ir("f0", 8'h00, 8'h00, 8'h02, 1'b1);
    check("wrap1", 32'(b_pc), 32'hFE);
    step();
    check_ir("f1", 8'hD3, 8'h02, 8'h04, 1'b1);
    check("f1.count", 32'(a_count), 32'h1);
    check("wrap2", 32'(b_pc), 32'h00);

    // Backpressure holding D3
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ir("bp", 8'hD3, 8'h02, 8'h04, 1'b1);
      check("bp.count", 32'(a_count), 32'h1);
    end
    instr_ready = 1'b1;
    step();
    check_ir("rel", 8'h50, 8'h04, 8'h06, 1'b1);
    check("rel.count", 32'(a_count), 32'h2);
    check("wrap3", 32'(b_pc), 32'h02);
    step();
    check_ir("f3", 8'hD1, 8'h06, 8'h08, 1'b1);
    check("f3.count", 32'(a_count), 32'h3);

    // Branch to odd target 07 while pc=08
    branch_en = 1'b1; branch_target = 8'h07;
    step();
    branch_en = 1'b0;
    check("br.valid", 32'(a_valid), 32'h0);
    check("br.pc", 32'(a_pc), 32'h06);
    check("br.count", 32'(a_count), 32'h4);
    step();
    check_ir("br1", 8'hD1, 8'h06, 8'h08, 1'b1);
    check("br1.count", 32'(a_count), 32'h4);
    step();
    check_ir("br2", 8'h51, 8'h08, 8'h0A, 1'b1);
    check("br2.count", 32'(a_count), 32'h5);

    // Halt with a pending instruction under backpressure
    instr_ready = 1'b0; halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt.running", 32'(a_running), 32'h0);
    check_ir("halt", 8'h51, 8'h08, 8'h0A, 1'b1);
    step();
    check_ir("halt2", 8'h51, 8'h08, 8'h0A, 1'b1);
    instr_ready = 1'b1;
    step();
    check("halt.acc.valid", 32'(a_valid), 32'h0);
    check("halt.acc.count", 32'(a_count), 32'h6);
    step();
    check("halt.idle.count", 32'(a_count), 32'h6);
    check("halt.idle.pc", 32'(a_pc), 32'h0A);
    start = 1'b1;
    step();
    start = 1'b0;
    check("resume.running", 32'(a_running), 32'h1);
    check("resume.valid", 32'(a_valid), 32'h0);
    instr_ready = 1'b0;
    step();
    check_ir("resume", 8'h10, 8'h0A, 8'h0C, 1'b1);

    // Asynchronous reset mid-cycle with a valid instruction pending
    step();
    reset = 1'b1;
    #2;
    check_ir("arst", 8'h00, 8'h00, 8'h00, 1'b0);
    check("arst.count", 32'(a_count), 32'h0);
    check("arst.running", 32'(a_running), 32'h0);
    check("arst.pc_b", 32'(b_pc), 32'hFC);
    #2;
    reset = 1'b0;

    // Saturation: narrow counter in instance B
    start = 1'b1; instr_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 19; i++) step();
    check("sat.count_a", 32'(a_count), 32'd18);
    check("sat.count_b", 32'(b_count), 32'hF);
    for (int i = 0; i < 5; i++) step();
    check("sat2.count_a", 32'(a_count), 32'd23);
    check("sat2.count_b", 32'(b_count), 32'hF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_fetch_unit

`default_nettype wire
